clock_chain_ctrl: RTL and testbench
===================================

Name: clock_chain_ctrl

Overview:
- Controller that sequences a chain of six 4-bit synchronous counter slices forming a 24-hour BCD clock, HH:MM:SS.
- Slice ports: active-low sync load, dual count enables, 4-bit parallel load data, 4-bit Q output.
- Generates the 1 Hz tick, per-slice count enables and modulo wrap loads, plus a button-driven time-set state machine.
- The counter slices share CP and NotCR with this block.

Parameters:
TICK_DIV, 100000000, CP cycles per tick (1 s); minimum 4.
TICK_W, 27, prescaler width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
CP  input  1  system clock, rising edge.
NotCR  input  1  asynchronous active-low reset.
mode_btn  input  1  single-cycle pulse; advances set state.
inc_btn  input  1  single-cycle pulse; increments selected field in set states.
Q_in  input  24  slice outputs {hr_t,hr_o,min_t,min_o,sec_t,sec_o}, bits [23:20]..[3:0].
NotLD  output  6  per-slice active-low load, index 0 = sec_o.
CTp  output  6  per-slice count enable P.
CTt  output  6  per-slice count enable T.
D  output  24  per-slice load data, same packing as Q_in.
state  output  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
tick  output  1  registered one-cycle pulse every TICK_DIV cycles.
blank  output  6  per-slice display blank mask (see Optional Feature).

Behaviour:
- Reset (NotCR low, asynchronous): prescaler=0, tick=0, state=RUN. All outputs settle immediately: NotLD=6'h3F, CTp=CTt=0, D=0, blank=0.
- Prescaler: counts 0..TICK_DIV-1, then wraps to 0. tick is registered high for exactly the cycle after cnt==TICK_DIV-1. The prescaler runs in every state.
- FSM:
  - mode_btn: RUN->SET_HR->SET_MIN->SET_SEC->RUN. State is updated at the next CP edge.
  - mode_btn and inc_btn in the same cycle: mode wins, inc is ignored that cycle.
- Event source:
  - RUN: ev_sec = tick.
  - SET_HR: ev_hr = inc_btn.
  - SET_MIN: ev_min = inc_btn.
  - SET_SEC: ev_sec = inc_btn.
  - tick is ignored in all set states.
- Carry chain (RUN only):
  - c0 = ev_sec & sec_o>=9
  - c1 = c0 & sec_t>=5
  - c2 = c1 & min_o>=9
  - c3 = c2 & min_t>=5 (c3 drives hr_o)
  - In set states the carry does not leave the selected field; the field wraps to 00 with no increment of the next field.
- Per-slice enable e_i = event reaching that slice (ev or incoming carry).
- Terminal value per slice: 9 for *_o, 5 for sec_t/min_t. Hours use the rules below.
- Slice outputs:
  - e_i=1 and digit below terminal: CTp_i=CTt_i=1, NotLD_i=1.
  - e_i=1 and digit at or above terminal (covers illegal values): NotLD_i=0, D_i=0, CTp_i=CTt_i=0.
  - e_i=0: NotLD_i=1, CTp_i=CTt_i=0.
- Hours:
  - Event with {hr_t,hr_o}>=23 (hr_t>=2 & hr_o>=3, or hr_t>=3): load both hour slices to 0.
  - Else if hr_o>=9: load hr_o to 0 and enable hr_t.
  - Else: enable hr_o.
- Control outputs are combinational from state, tick, buttons and Q_in. Slices update at the CP edge ending the event cycle, so new time is visible 1 cycle after tick/inc.
- D is 0 for every slice at all times. No preset load values are used.
- tick coincident with mode_btn in RUN: the tick is processed in RUN; the state changes next cycle.

Optional Feature:
- Macro CLOCK_CHAIN_CTRL_BLINK_EN.
- Defined: in set states, blank bits of the selected field's two slices are 1 while cnt >= TICK_DIV/2, else 0. blank=0 in RUN and during reset.
- Undefined: blank tied to 6'h00. No half-period compare logic is built.

Test Plan:
All scenarios use TICK_DIV=4 and a behavioural 4-bit slice model.
1. Release reset with Q_in=0 -> tick high on 4th cycle after release; CTp[0]=CTt[0]=1, NotLD=6'h3F; sec_o=1 the next cycle.
2. Q_in=23:59:59, tick -> NotLD=6'h00, D=0; chain reads 00:00:00 the next cycle.
3. Q_in=12:34:59, tick -> NotLD=6'h3C, CTp=CTt=6'b000100; next value 12:35:00.
4. One mode_btn -> state=1; inc_btn with hours=23 -> NotLD[5:4]=00, all others idle; a tick in SET_HR -> no enables asserted.
5. SET_MIN with 10:59:30, inc_btn -> minutes become 00, hours stay 10. mode_btn+inc_btn in the same cycle -> state=3, no enables.
6. NotCR low for 1 cycle at cnt=2 in SET_SEC -> state=0, tick=0, outputs idle immediately; next tick arrives 4 cycles after release.

Source files
------------

// File: rtl/clock_chain_ctrl_if.sv
// Slice-side bus between the clock controller and its six 4-bit counter slices.
// Digit packing everywhere is {hr_t,hr_o,min_t,min_o,sec_t,sec_o}, index 0 = sec_o.
interface clock_chain_ctrl_if;
    logic [23:0] Q_in;
    logic [5:0]  NotLD;
    logic [5:0]  CTp;
    logic [5:0]  CTt;
    logic [23:0] D;
    logic [5:0]  blank;

    modport master (
        input  Q_in,
        output NotLD,
        output CTp,
        output CTt,
        output D,
        output blank
    );

    modport slave (
        output Q_in,
        input  NotLD,
        input  CTp,
        input  CTt,
        input  D,
        input  blank
    );
endinterface

// File: rtl/clock_chain_ctrl.sv
// Sequencer for a six-slice BCD HH:MM:SS counter chain: 1 Hz prescaler, carry/wrap
// control and button time-set FSM. Optional blink mask under CLOCK_CHAIN_CTRL_BLINK_EN.
module clock_chain_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned TICK_W   = 27
) (
    input  logic                CP,
    input  logic                NotCR,
    input  logic                mode_btn,
    input  logic                inc_btn,
    clock_chain_ctrl_if.master  slc,
    output logic [1:0]          state,
    output logic                tick
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_e;

    localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

    mode_e             st_q;
    logic [TICK_W-1:0] cnt;

    // Prescaler, tick pulse and set-mode state machine
    always_ff @(posedge CP or negedge NotCR) begin
        if (!NotCR) begin
            cnt  <= '0;
            tick <= 1'b0;
            st_q <= RUN;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + TICK_W'(1);
            tick <= (cnt == CNT_LAST);
            if (mode_btn) begin
                case (st_q)
                    RUN:     st_q <= SET_HR;
                    SET_HR:  st_q <= SET_MIN;
                    SET_MIN: st_q <= SET_SEC;
                    default: st_q <= RUN;
                endcase
            end
        end
    end

    assign state = st_q;

    logic [3:0] dig [6];
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            dig[i] = slc.Q_in[4*i +: 4];
        end
    end

    logic       run;
    logic       inc_ok;
    logic       ev_sec;
    logic       ev_min;
    logic       ev_hr;
    logic       ev_hr_all;
    logic [3:0] en;
    logic [3:0] term;
    logic [5:0] notld;
    logic [5:0] cten;

    // Event routing, carry chain and per-slice count/load decode
    always_comb begin
        notld     = 6'h3F;
        cten      = 6'h00;
        term      = 4'd9;
        run       = (st_q == RUN);
        inc_ok    = inc_btn & ~mode_btn;
        ev_sec    = run ? tick : ((st_q == SET_SEC) & inc_ok);
        ev_min    = (st_q == SET_MIN) & inc_ok;
        ev_hr     = (st_q == SET_HR) & inc_ok;

        // Carries only cross field boundaries while running
        en[0]     = ev_sec;
        en[1]     = en[0] & (dig[0] >= 4'd9);
        en[2]     = ev_min | (run & en[1] & (dig[1] >= 4'd5));
        en[3]     = en[2] & (dig[2] >= 4'd9);
        ev_hr_all = ev_hr | (run & en[3] & (dig[3] >= 4'd5));

        for (int i = 0; i < 4; i++) begin
            term = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
            if (en[i]) begin
                if (dig[i] >= term) begin
                    notld[i] = 1'b0;
                end else begin
                    cten[i] = 1'b1;
                end
            end
        end

        // Hours: 23 (or any illegal tens) wraps both digits to 00
        if (ev_hr_all) begin
            if (((dig[5] >= 4'd2) && (dig[4] >= 4'd3)) || (dig[5] >= 4'd3)) begin
                notld[5:4] = 2'b00;
            end else if (dig[4] >= 4'd9) begin
                notld[4] = 1'b0;
                cten[5]  = 1'b1;
            end else begin
                cten[4]  = 1'b1;
            end
        end
    end

    assign slc.NotLD = notld;
    assign slc.CTp   = cten;
    assign slc.CTt   = cten;
    assign slc.D     = '0;

`ifdef CLOCK_CHAIN_CTRL_BLINK_EN
    localparam logic [TICK_W-1:0] CNT_HALF = TICK_W'(TICK_DIV / 2);

    logic [5:0] blank_mask;

    // Blank the field being edited during the second half of each second
    always_comb begin
        blank_mask = 6'h00;
        if (cnt >= CNT_HALF) begin
            case (st_q)
                SET_HR:  blank_mask = 6'b110000;
                SET_MIN: blank_mask = 6'b001100;
                SET_SEC: blank_mask = 6'b000011;
                default: blank_mask = 6'h00;
            endcase
        end
    end

    assign slc.blank = blank_mask;
`else
    assign slc.blank = 6'h00;
`endif

endmodule

// File: tb/tb_clock_chain_ctrl.sv
// Bench for clock_chain_ctrl: behavioural counter slices plus a seconds-arithmetic
// time model; directed steps with randomized times.
module tb_clock_chain_ctrl;
    localparam int unsigned TD = 4;
    localparam int unsigned TW = 3;

    logic       CP       = 1'b0;
    logic       NotCR    = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [1:0] state;
    logic       tick;

    clock_chain_ctrl_if slc ();

    clock_chain_ctrl #(.TICK_DIV(TD), .TICK_W(TW)) dut (
        .CP       (CP),
        .NotCR    (NotCR),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .slc      (slc),
        .state    (state),
        .tick     (tick)
    );

    always #5 CP = ~CP;

    // Behavioural 4-bit slices with async clear, sync load, dual enable; preset hook
    logic [23:0] q       = '0;
    logic        pre_en  = 1'b0;
    logic [23:0] pre_val = '0;
    assign slc.Q_in = q;

    always @(posedge CP or negedge NotCR) begin
        if (!NotCR) begin
            q <= '0;
        end else if (pre_en) begin
            q <= pre_val;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!slc.NotLD[i])
                    q[4*i +: 4] <= slc.D[4*i +: 4];
                else if (slc.CTp[i] && slc.CTt[i])
                    q[4*i +: 4] <= q[4*i +: 4] + 4'd1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int t     = 0;

    function automatic int mk(int h, int m, int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] pack_t(int tt);
        int h, m, s;
        h = tt / 3600;
        m = (tt / 60) % 60;
        s = tt % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // kind: 0 = running tick, 1/2/3 = increment hours/minutes/seconds field alone
    function automatic int next_t(int tt, int kind);
        int h, m, s;
        h = tt / 3600;
        m = (tt / 60) % 60;
        s = tt % 60;
        case (kind)
            0:       return (tt + 1) % 86400;
            1:       return mk((h + 1) % 24, m, s);
            2:       return mk(h, (m + 1) % 60, s);
            default: return mk(h, m, (s + 1) % 60);
        endcase
    endfunction

    // A digit that changes is loaded when it becomes 0, otherwise counted
    function automatic logic [11:0] ctl(logic [23:0] o, logic [23:0] n);
        logic [5:0] nl, cp;
        nl = 6'h3F;
        cp = 6'h00;
        for (int i = 0; i < 6; i++) begin
            if (o[4*i +: 4] != n[4*i +: 4]) begin
                if (n[4*i +: 4] == 4'd0) nl[i] = 1'b0;
                else                     cp[i] = 1'b1;
            end
        end
        return {nl, cp};
    endfunction

    function automatic int rand_time();
        int h, m, s;
        h = int'($urandom_range(0, 23));
        m = int'($urandom_range(0, 59));
        s = int'($urandom_range(0, 59));
        if ($urandom_range(0, 1) == 1) s = 59;
        if ($urandom_range(0, 1) == 1) m = 59;
        if ($urandom_range(0, 2) == 0) h = (h % 3 == 0) ? 9 : ((h % 3 == 1) ? 19 : 23);
        return mk(h, m, s);
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge CP);
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (n >= 40) check("tick_timeout", 24'(tick), 24'd1);
    endtask

    task automatic preset(input int nt);
        pre_val = pack_t(nt);
        pre_en  = 1'b1;
        @(negedge CP);
        pre_en  = 1'b0;
        t       = nt;
    endtask

    // Event inputs already applied at this negedge; check decode, then the new time
    task automatic event_chk(input string tag, input int kind);
        int          nt;
        logic [11:0] e;
        nt = next_t(t, kind);
        e  = ctl(pack_t(t), pack_t(nt));
        #1;
        check({tag, "_notld"}, 24'(slc.NotLD), 24'(e[11:6]));
        check({tag, "_ctp"},   24'(slc.CTp),   24'(e[5:0]));
        check({tag, "_ctt"},   24'(slc.CTt),   24'(e[5:0]));
        check({tag, "_d"},     slc.D,          24'd0);
        @(negedge CP);
        inc_btn = 1'b0;
        t = nt;
        #1;
        check({tag, "_q"}, q, pack_t(t));
    endtask

    task automatic idle_chk(input string tag);
        #1;
        check({tag, "_notld"}, 24'(slc.NotLD), 24'h3F);
        check({tag, "_ctp"},   24'(slc.CTp),   24'd0);
        check({tag, "_ctt"},   24'(slc.CTt),   24'd0);
    endtask

    task automatic press_mode(input logic [1:0] exp_state);
        mode_btn = 1'b1;
        @(negedge CP);
        mode_btn = 1'b0;
        #1;
        check("mode_state", 24'(state), 24'(exp_state));
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge CP);
        #1;
        check("rst_state", 24'(state), 24'd0);
        check("rst_tick",  24'(tick),  24'd0);
        idle_chk("rst");
        check("rst_d",     slc.D,           24'd0);
        check("rst_blank", 24'(slc.blank),  24'd0);

        // First tick latency and first second
        @(negedge CP);
        NotCR = 1'b1;
        t = 0;
        wait_tick(n);
        check("first_tick_latency", 24'(n), 24'd4);
        event_chk("first_sec", 0);

        // Full rollover and a minute carry
        preset(mk(23, 59, 59));
        wait_tick(n);
        event_chk("day_wrap", 0);
        preset(mk(12, 34, 59));
        wait_tick(n);
        event_chk("min_carry", 0);

        // Randomized running ticks
        for (int k = 0; k < 16; k++) begin
            preset(rand_time());
            wait_tick(n);
            check("tick_period", 24'(n), 24'd2);
            event_chk("run_rand", 0);
        end

        // SET_HR: hour wrap and ignored tick
        preset(mk(23, 15, 42));
        press_mode(2'd1);
        @(negedge CP);
        #1;
        check("sethr_tick_seen", 24'(tick), 24'd1);
        idle_chk("sethr_tick");
        @(negedge CP);
        #1;
        check("sethr_tick_q", q, pack_t(t));
        inc_btn = 1'b1;
        event_chk("hr_wrap", 1);
        for (int k = 0; k < 6; k++) begin
            preset(rand_time());
            inc_btn = 1'b1;
            event_chk("hr_rand", 1);
        end

        // SET_MIN: minute wrap stays inside the field
        press_mode(2'd2);
        preset(mk(10, 59, 30));
        inc_btn = 1'b1;
        event_chk("min_wrap", 2);
        for (int k = 0; k < 6; k++) begin
            preset(rand_time());
            inc_btn = 1'b1;
            event_chk("min_rand", 2);
        end

        // mode and inc together: mode wins, no enables
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        idle_chk("mode_inc");
        @(negedge CP);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        #1;
        check("mode_inc_state", 24'(state), 24'd3);
        check("mode_inc_q",     q,          pack_t(t));

        // SET_SEC: second wrap stays inside the field
        preset(mk(10, 0, 59));
        inc_btn = 1'b1;
        event_chk("sec_wrap", 3);
        for (int k = 0; k < 6; k++) begin
            preset(rand_time());
            inc_btn = 1'b1;
            event_chk("sec_rand", 3);
        end

        // Async reset mid-period at cnt=2 while an inc is pending
        wait_tick(n);
        repeat (2) @(negedge CP);
        inc_btn = 1'b1;
        NotCR   = 1'b0;
        #1;
        check("arst_state", 24'(state), 24'd0);
        check("arst_tick",  24'(tick),  24'd0);
        idle_chk("arst");
        check("arst_blank", 24'(slc.blank), 24'd0);
        check("arst_q",     q,              24'd0);
        t = 0;
        @(negedge CP);
        inc_btn = 1'b0;
        NotCR   = 1'b1;
        wait_tick(n);
        check("arst_tick_latency", 24'(n), 24'd4);
        event_chk("arst_run", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
